// File: rtl/sd_writer_pkg.sv
// Shared register map, command codes and state encodings for the SD log block writer.
package sd_writer_pkg;

    localparam logic [5:0] REG_TRANS_TYPE    = 6'h02;
    localparam logic [5:0] REG_TRANS_CTRL    = 6'h03;
    localparam logic [5:0] REG_TRANS_STS     = 6'h04;
    localparam logic [5:0] REG_TRANS_ERROR   = 6'h05;
    localparam logic [5:0] REG_SD_ADDR_7_0   = 6'h07;
    localparam logic [5:0] REG_SD_ADDR_15_8  = 6'h08;
    localparam logic [5:0] REG_SD_ADDR_23_16 = 6'h09;
    localparam logic [5:0] REG_SD_ADDR_31_24 = 6'h0A;
    localparam logic [5:0] REG_RX_FIFO       = 6'h10;
    localparam logic [5:0] REG_TX_FIFO_DATA  = 6'h20;
    localparam logic [5:0] REG_TX_FIFO_CTRL  = 6'h24;

    localparam logic [7:0] TYPE_INIT     = 8'd1;
    localparam logic [7:0] TYPE_RW_WRITE = 8'd3;
    localparam logic [7:0] CTRL_START    = 8'd1;
    localparam logic [7:0] FIFO_CLEAR    = 8'd1;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_INIT    = 2'd1;
    localparam logic [1:0] ERR_WRITE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [9:0]  SECTOR_LAST = 10'd511;
    localparam logic [23:0] TMO_MAX     = 24'hFF_FFFF;

    typedef enum logic [4:0] {
        ST_IDLE, ST_INIT_TYPE, ST_INIT_GO, ST_INIT_POLL, ST_INIT_CHK,
        ST_FIFO_CLR, ST_FILL, ST_PAD, ST_ADDR0, ST_ADDR1, ST_ADDR2, ST_ADDR3,
        ST_W_TYPE, ST_W_GO, ST_W_POLL, ST_W_CHK, ST_ERROR
    } state_t;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_STROBE, SEQ_CAPTURE} seq_phase_t;

    function automatic logic [31:0] sd_address(input logic [31:0] sector, input logic byte_addr);
        return byte_addr ? (sector << 9) : sector;
    endfunction

endpackage

// File: rtl/sd_bus_seq.sv
// Single register access sequencer: strobe cycle, capture cycle, then a one-cycle done.
module sd_bus_seq
    import sd_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_we,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [7:0] spi_dat_i,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic       spi_strobe,
    output logic       spi_we,
    output logic [5:0] spi_addr,
    output logic [7:0] spi_dat_o
);

    seq_phase_t phase;

    // Holding off while done is high guarantees an idle gap between strobes.
    assign ready = (phase == SEQ_IDLE) && !done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= SEQ_IDLE;
            done       <= 1'b0;
            rdata      <= 8'h00;
            spi_strobe <= 1'b0;
            spi_we     <= 1'b0;
            spi_addr   <= 6'h00;
            spi_dat_o  <= 8'h00;
        end else begin
            spi_strobe <= 1'b0;
            done       <= 1'b0;
            case (phase)
                SEQ_IDLE: begin
                    if (req && ready) begin
                        spi_strobe <= 1'b1;
                        spi_we     <= req_we;
                        spi_addr   <= req_addr;
                        spi_dat_o  <= req_wdata;
                        phase      <= SEQ_STROBE;
                    end
                end
                SEQ_STROBE: phase <= SEQ_CAPTURE;
                SEQ_CAPTURE: begin
                    rdata <= spi_dat_i;
                    done  <= 1'b1;
                    phase <= SEQ_IDLE;
                end
                default: phase <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sd_log_block_writer.sv
// Streams log bytes into 512-byte SD sectors through a register-mapped SPI SD master.
module sd_log_block_writer
    import sd_writer_pkg::*;
#(
    parameter logic [31:0] BASE_SECTOR = 32'd0,
    parameter int          BYTE_ADDR   = 1,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic        clk_peri,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [5:0]  spi_addr,
    output logic [7:0]  spi_dat_o,
    input  logic [7:0]  spi_dat_i,
    output logic        spi_strobe,
    output logic        spi_we,
    output logic        busy,
    output logic        init_done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [31:0] sectors_written
);

    state_t      state, state_next;
    logic [9:0]  byte_cnt;
    logic [23:0] tmo;
    logic        flush_pend;
    logic        req, req_we, seq_ready, seq_done;
    logic [5:0]  req_addr;
    logic [7:0]  req_wdata, rdata;
    logic        cnt_inc, cnt_clr, flush_clr, set_init, go_idle, inc_sec, set_err;
    logic [1:0]  err_val;
    logic [31:0] sd_addr;
    logic        in_poll;

    assign sd_addr = sd_address(BASE_SECTOR + sectors_written, BYTE_ADDR != 0);
    assign in_poll = (state == ST_INIT_POLL) || (state == ST_W_POLL);
    assign busy    = !((state == ST_IDLE) || (state == ST_ERROR) ||
                       ((state == ST_FILL) && (byte_cnt == 10'd0)));

    sd_bus_seq u_seq (
        .clk(clk_peri), .rst(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .spi_dat_i(spi_dat_i), .ready(seq_ready), .done(seq_done),
        .rdata(rdata), .spi_strobe(spi_strobe), .spi_we(spi_we), .spi_addr(spi_addr),
        .spi_dat_o(spi_dat_o)
    );

    always_ff @(posedge clk_peri or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            byte_cnt        <= 10'd0;
            tmo             <= 24'd0;
            flush_pend      <= 1'b0;
            init_done       <= 1'b0;
            error           <= 1'b0;
            err_code        <= ERR_NONE;
            sectors_written <= 32'd0;
        end else begin
            state <= state_next;
            if (cnt_clr)
                byte_cnt <= 10'd0;
            else if (cnt_inc)
                byte_cnt <= (byte_cnt == SECTOR_LAST) ? 10'd0 : byte_cnt + 10'd1;
            tmo <= in_poll ? ((tmo == TMO_MAX) ? tmo : tmo + 24'd1) : 24'd0;
            // A fresh flush pulse wins over clearing the one being serviced.
            if (flush && state != ST_IDLE && state != ST_ERROR && !go_idle)
                flush_pend <= 1'b1;
            else if (flush_clr || go_idle)
                flush_pend <= 1'b0;
            if (go_idle) begin
                init_done <= 1'b0;
                error     <= 1'b0;
                err_code  <= ERR_NONE;
            end else begin
                if (set_init) init_done <= 1'b1;
                if (set_err) begin
                    error    <= 1'b1;
                    err_code <= err_val;
                end
            end
            if (inc_sec) sectors_written <= sectors_written + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        req_we     = 1'b1;
        req_addr   = REG_TRANS_TYPE;
        req_wdata  = 8'h00;
        din_ready  = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        flush_clr  = 1'b0;
        set_init   = 1'b0;
        go_idle    = 1'b0;
        inc_sec    = 1'b0;
        set_err    = 1'b0;
        err_val    = ERR_NONE;
        if (state == ST_ERROR) begin
            if (!enable) begin
                state_next = ST_IDLE;
                go_idle    = 1'b1;
            end
        end else if (state != ST_IDLE && !enable && seq_ready) begin
            state_next = ST_IDLE;
            go_idle    = 1'b1;
        end else if (in_poll && tmo == TMO_MAX) begin
            state_next = ST_ERROR;
            set_err    = 1'b1;
            err_val    = ERR_TIMEOUT;
        end else begin
            case (state)
                ST_IDLE: if (enable) state_next = ST_INIT_TYPE;
                ST_INIT_TYPE, ST_W_TYPE: begin
                    req       = seq_ready;
                    req_addr  = REG_TRANS_TYPE;
                    req_wdata = (state == ST_INIT_TYPE) ? TYPE_INIT : TYPE_RW_WRITE;
                    if (seq_done) state_next = (state == ST_INIT_TYPE) ? ST_INIT_GO : ST_W_GO;
                end
                ST_INIT_GO, ST_W_GO: begin
                    req       = seq_ready;
                    req_addr  = REG_TRANS_CTRL;
                    req_wdata = CTRL_START;
                    if (seq_done) state_next = (state == ST_INIT_GO) ? ST_INIT_POLL : ST_W_POLL;
                end
                ST_INIT_POLL, ST_W_POLL: begin
                    req      = seq_ready;
                    req_we   = 1'b0;
                    req_addr = REG_TRANS_STS;
                    if (seq_done && !rdata[0])
                        state_next = (state == ST_INIT_POLL) ? ST_INIT_CHK : ST_W_CHK;
                end
                ST_INIT_CHK, ST_W_CHK: begin
                    req      = seq_ready;
                    req_we   = 1'b0;
                    req_addr = REG_TRANS_ERROR;
                    if (seq_done) begin
                        if (rdata == 8'h00) begin
                            state_next = ST_FIFO_CLR;
                            set_init   = (state == ST_INIT_CHK);
                            inc_sec    = (state == ST_W_CHK);
                        end else begin
                            state_next = ST_ERROR;
                            set_err    = 1'b1;
                            err_val    = (state == ST_INIT_CHK) ? ERR_INIT : ERR_WRITE;
                        end
                    end
                end
                ST_FIFO_CLR: begin
                    req       = seq_ready;
                    req_addr  = REG_TX_FIFO_CTRL;
                    req_wdata = FIFO_CLEAR;
                    if (seq_done) begin
                        cnt_clr    = 1'b1;
                        state_next = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (seq_done && byte_cnt == 10'd0) begin
                        state_next = ST_ADDR0;
                    end else if (seq_ready && flush_pend) begin
                        flush_clr = 1'b1;
                        if (byte_cnt != 10'd0) state_next = ST_PAD;
                    end else begin
                        din_ready = seq_ready;
                        if (din_valid && seq_ready) begin
                            req       = 1'b1;
                            req_addr  = REG_TX_FIFO_DATA;
                            req_wdata = din;
                            cnt_inc   = 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    if (seq_done && byte_cnt == 10'd0) begin
                        state_next = ST_ADDR0;
                    end else if (seq_ready && byte_cnt != 10'd0) begin
                        req       = 1'b1;
                        req_addr  = REG_TX_FIFO_DATA;
                        req_wdata = PAD_BYTE;
                        cnt_inc   = 1'b1;
                    end
                end
                ST_ADDR0: begin
                    req       = seq_ready;
                    req_addr  = REG_SD_ADDR_7_0;
                    req_wdata = sd_addr[7:0];
                    if (seq_done) state_next = ST_ADDR1;
                end
                ST_ADDR1: begin
                    req       = seq_ready;
                    req_addr  = REG_SD_ADDR_15_8;
                    req_wdata = sd_addr[15:8];
                    if (seq_done) state_next = ST_ADDR2;
                end
                ST_ADDR2: begin
                    req       = seq_ready;
                    req_addr  = REG_SD_ADDR_23_16;
                    req_wdata = sd_addr[23:16];
                    if (seq_done) state_next = ST_ADDR3;
                end
                ST_ADDR3: begin
                    req       = seq_ready;
                    req_addr  = REG_SD_ADDR_31_24;
                    req_wdata = sd_addr[31:24];
                    if (seq_done) state_next = ST_W_TYPE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_log_block_writer.sv
// Directed bench: SPI register model, access log, two DUTs differing only in BASE_SECTOR.
module tb_sd_log_block_writer;

    typedef logic [14:0] acc_t;  // {we, addr[5:0], data[7:0]}

    logic        clk_peri = 1'b0;
    logic        reset, enable, flush, din_valid;
    logic [7:0]  din;
    logic [7:0]  spi_dat_i = 8'h00;

    logic        din_ready, spi_strobe, spi_we, busy, init_done, error;
    logic [5:0]  spi_addr;
    logic [7:0]  spi_dat_o;
    logic [1:0]  err_code;
    logic [31:0] sectors_written;

    logic        din_ready_b, spi_strobe_b, spi_we_b, busy_b, init_done_b, error_b;
    logic [5:0]  spi_addr_b;
    logic [7:0]  spi_dat_o_b;
    logic [1:0]  err_code_b;
    logic [31:0] sectors_written_b;

    acc_t       log_q[$];
    logic [7:0] addr_b_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         init_polls = 10;
    int         write_polls = 3;
    logic [7:0] write_err = 8'h00;
    logic [7:0] last_type = 8'h00;
    int         sts_reads = 0;

    always #5 clk_peri = ~clk_peri;

    sd_log_block_writer dut (
        .clk_peri(clk_peri), .reset(reset), .enable(enable), .flush(flush), .din(din),
        .din_valid(din_valid), .din_ready(din_ready), .spi_addr(spi_addr), .spi_dat_o(spi_dat_o),
        .spi_dat_i(spi_dat_i), .spi_strobe(spi_strobe), .spi_we(spi_we), .busy(busy),
        .init_done(init_done), .error(error), .err_code(err_code), .sectors_written(sectors_written)
    );

    sd_log_block_writer #(.BASE_SECTOR(32'd5), .BYTE_ADDR(1)) dut_b (
        .clk_peri(clk_peri), .reset(reset), .enable(enable), .flush(flush), .din(din),
        .din_valid(din_valid), .din_ready(din_ready_b), .spi_addr(spi_addr_b), .spi_dat_o(spi_dat_o_b),
        .spi_dat_i(spi_dat_i), .spi_strobe(spi_strobe_b), .spi_we(spi_we_b), .busy(busy_b),
        .init_done(init_done_b), .error(error_b), .err_code(err_code_b),
        .sectors_written(sectors_written_b)
    );

    // SPI master model: answers STS/ERROR reads, drives read data through the following cycle.
    always @(negedge clk_peri) begin
        if (spi_strobe) begin
            log_q.push_back({spi_we, spi_addr, spi_we ? spi_dat_o : 8'h00});
            if (spi_we) begin
                if (spi_addr == 6'h02) last_type = spi_dat_o;
                if (spi_addr == 6'h03) sts_reads = 0;
            end else if (spi_addr == 6'h04) begin
                sts_reads++;
                spi_dat_i = (sts_reads < ((last_type == 8'd1) ? init_polls : write_polls)) ? 8'h01 : 8'h00;
            end else if (spi_addr == 6'h05) begin
                spi_dat_i = (last_type == 8'd1) ? 8'h00 : write_err;
            end else begin
                spi_dat_i = 8'h00;
            end
        end
        if (spi_strobe_b && spi_we_b && spi_addr_b >= 6'h07 && spi_addr_b <= 6'h0A)
            addr_b_q.push_back(spi_dat_o_b);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_peri);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin tick(1); k++; end
        n_checks++;
        if (log_q.size() < n) begin
            n_fail++;
            $display("FAIL wait_log: access count %0d, required %0d", log_q.size(), n);
        end
    endtask

    task automatic wait_init(input int budget);
        int k = 0;
        while (init_done !== 1'b1 && k < budget) begin tick(1); k++; end
        n_checks++;
        if (init_done !== 1'b1) begin n_fail++; $display("FAIL wait_init: init_done %b, required 1", init_done); end
    endtask

    task automatic wait_sectors(input int n, input int budget);
        int k = 0;
        while (sectors_written != n && k < budget) begin tick(1); k++; end
        n_checks++;
        if (sectors_written !== n) begin
            n_fail++;
            $display("FAIL sectors_written: got %0d, required %0d", sectors_written, n);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        din = b;
        din_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk_peri);
            if (din_ready) begin @(posedge clk_peri); #1; ok = 1'b1; end
        end
        din_valid = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL send_byte: din_ready never high for byte %h", b);
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk_peri); flush = 1'b1;
        @(negedge clk_peri); flush = 1'b0;
    endtask

    // Block-write tail expected after the data bytes, starting at index 512.
    task automatic check_write_tail(input logic [31:0] addr, input logic [31:0] addr_b);
        logic [31:0] got_b;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (log_q[512+i] !== {1'b1, 6'(7 + i), addr[8*i +: 8]}) begin
                n_fail++;
                $display("FAIL sd_addr byte %0d: got %h, required %h", i, log_q[512+i], {1'b1, 6'(7 + i), addr[8*i +: 8]});
            end
        end
        n_checks++;
        if (log_q[516] !== {1'b1, 6'h02, 8'h03} || log_q[517] !== {1'b1, 6'h03, 8'h01}) begin
            n_fail++;
            $display("FAIL write_type_start: got %h %h, required %h %h", log_q[516], log_q[517],
                     {1'b1, 6'h02, 8'h03}, {1'b1, 6'h03, 8'h01});
        end
        n_checks++;
        if (log_q[518] !== {1'b0, 6'h04, 8'h00} || log_q[520] !== {1'b0, 6'h04, 8'h00} ||
            log_q[521] !== {1'b0, 6'h05, 8'h00} || log_q[522] !== {1'b1, 6'h24, 8'h01}) begin
            n_fail++;
            $display("FAIL write_poll_chk: got %h %h %h %h", log_q[518], log_q[520], log_q[521], log_q[522]);
        end
        got_b = {addr_b_q[3], addr_b_q[2], addr_b_q[1], addr_b_q[0]};
        n_checks++;
        if (addr_b_q.size() != 4 || got_b !== addr_b) begin
            n_fail++;
            $display("FAIL base5_addr: got %h (%0d bytes), required %h", got_b, addr_b_q.size(), addr_b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; flush = 1'b0; din_valid = 1'b0; din = 8'h00;
        tick(3);
        n_checks++;
        if ({spi_strobe, spi_we, din_ready, busy, init_done, error, err_code, sectors_written, spi_addr, spi_dat_o} !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got strobe=%b we=%b rdy=%b busy=%b init=%b err=%b code=%0d sec=%0d addr=%h dat=%h, required all 0",
                     spi_strobe, spi_we, din_ready, busy, init_done, error, err_code, sectors_written, spi_addr, spi_dat_o);
        end
        @(negedge clk_peri); reset = 1'b0;
        tick(5);
        n_checks++;
        if (busy !== 1'b0 || log_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy %b accesses %0d, required 0 0", busy, log_q.size());
        end
    endtask

    task automatic test_init();
        int bad = 0;
        enable = 1'b1;
        wait_log(14, 1000);
        tick(5);
        n_checks++;
        if (log_q[0] !== {1'b1, 6'h02, 8'h01} || log_q[1] !== {1'b1, 6'h03, 8'h01}) begin
            n_fail++;
            $display("FAIL init_type_start: got %h %h, required %h %h", log_q[0], log_q[1],
                     {1'b1, 6'h02, 8'h01}, {1'b1, 6'h03, 8'h01});
        end
        for (int i = 2; i < 12; i++) if (log_q[i] !== {1'b0, 6'h04, 8'h00}) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL init_polls: %0d wrong entries, required 0", bad); end
        n_checks++;
        if (log_q[12] !== {1'b0, 6'h05, 8'h00} || log_q[13] !== {1'b1, 6'h24, 8'h01} || log_q.size() != 14) begin
            n_fail++;
            $display("FAIL init_chk_clr: got %h %h size %0d, required %h %h size 14", log_q[12], log_q[13],
                     log_q.size(), {1'b0, 6'h05, 8'h00}, {1'b1, 6'h24, 8'h01});
        end
        n_checks++;
        if ({init_done, busy, din_ready, error} !== 4'b1010) begin
            n_fail++;
            $display("FAIL init_status: got init/busy/rdy/err %b, required 1010", {init_done, busy, din_ready, error});
        end
        log_q.delete(); addr_b_q.delete();
    endtask

    task automatic test_full_sector();
        int bad = 0;
        for (int i = 0; i < 512; i++) send_byte(8'(i));
        wait_sectors(1, 1000);
        wait_log(523, 200);
        for (int i = 0; i < 512; i++) if (log_q[i] !== {1'b1, 6'h20, 8'(i)}) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL sector_data: %0d wrong fifo writes, required 0", bad); end
        check_write_tail(32'h0000_0000, 32'h0000_0A00);
        log_q.delete(); addr_b_q.delete();
    endtask

    task automatic test_flush_pad();
        int bad = 0;
        int hi = 0;
        int k = 0;
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_partial: got %b, required 1", busy); end
        pulse_flush();
        while (sectors_written != 2 && k < 5000) begin
            if (din_ready) hi++;
            @(negedge clk_peri); k++;
        end
        n_checks++;
        if (hi != 0) begin n_fail++; $display("FAIL pad_din_ready: high on %0d cycles, required 0", hi); end
        wait_sectors(2, 100);
        wait_log(523, 200);
        for (int i = 0; i < 3; i++) if (log_q[i] !== {1'b1, 6'h20, 8'(8'hA1 + i)}) bad++;
        for (int i = 3; i < 512; i++) if (log_q[i] !== {1'b1, 6'h20, 8'h00}) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL pad_data: %0d wrong fifo writes, required 0", bad); end
        check_write_tail(32'h0000_0200, 32'h0000_0C00);
        log_q.delete(); addr_b_q.delete();
        tick(10);
        pulse_flush();
        tick(40);
        n_checks++;
        if (log_q.size() != 0 || busy !== 1'b0 || din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_flush: accesses %0d busy %b rdy %b, required 0 0 1", log_q.size(), busy, din_ready);
        end
    endtask

    task automatic test_write_error();
        int n = 0;
        int k = 0;
        write_err = 8'h02;
        send_byte(8'h55);
        pulse_flush();
        while (error !== 1'b1 && k < 5000) begin tick(1); k++; end
        n_checks++;
        if (error !== 1'b1 || err_code !== 2'd2) begin
            n_fail++;
            $display("FAIL write_error: got error %b code %0d, required 1 2", error, err_code);
        end
        n = log_q.size();
        tick(50);
        n_checks++;
        if (log_q.size() != n || din_ready !== 1'b0 || busy !== 1'b0 || sectors_written !== 32'd2) begin
            n_fail++;
            $display("FAIL error_hold: accesses %0d->%0d rdy %b busy %b sec %0d, required no change 0 0 2",
                     n, log_q.size(), din_ready, busy, sectors_written);
        end
        enable = 1'b0;
        tick(3);
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL error_clear: got error %b busy %b, required 0 0", error, busy);
        end
        write_err = 8'h00;
    endtask

    task automatic test_reset_mid_write();
        int k = 0;
        write_polls = 1000;
        enable = 1'b1;
        wait_init(1000);
        send_byte(8'h77);
        pulse_flush();
        while (!(last_type == 8'd3 && sts_reads >= 3) && k < 5000) begin tick(1); k++; end
        n_checks++;
        if (!(last_type == 8'd3 && sts_reads >= 3)) begin
            n_fail++;
            $display("FAIL reach_w_poll: type %0d sts reads %0d, required 3 and >=3", last_type, sts_reads);
        end
        @(negedge clk_peri); reset = 1'b1;
        @(posedge clk_peri); #1;
        n_checks++;
        if ({spi_strobe, spi_we, din_ready, busy, init_done, error, err_code, sectors_written, spi_addr, spi_dat_o,
             spi_strobe_b, busy_b, sectors_written_b} !== 88'd0) begin
            n_fail++;
            $display("FAIL reset_mid_write: got strobe=%b rdy=%b busy=%b init=%b sec=%0d addr=%h dat=%h, required all 0",
                     spi_strobe, din_ready, busy, init_done, sectors_written, spi_addr, spi_dat_o);
        end
        log_q.delete();
        write_polls = 3;
        @(negedge clk_peri); reset = 1'b0;
        wait_log(2, 100);
        n_checks++;
        if (log_q[0] !== {1'b1, 6'h02, 8'h01} || log_q[1] !== {1'b1, 6'h03, 8'h01}) begin
            n_fail++;
            $display("FAIL restart_init: got %h %h, required %h %h", log_q[0], log_q[1],
                     {1'b1, 6'h02, 8'h01}, {1'b1, 6'h03, 8'h01});
        end
        wait_init(1000);
    endtask

    initial begin
        test_reset();
        test_init();
        test_full_sector();
        test_flush_pad();
        test_write_error();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
